// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler
//   Turns absolute target positions into relative chunked move commands for
//   one stepper channel. Each chunk goes into the channel's command FIFO as a
//   single-cycle write strobe. A credit counter that mirrors the free FIFO
//   slots makes sure the FIFO can never overflow.
//
// Ports
//   CLK_50MHZ        clock
//   rst              synchronous active-high reset
//   tgt_valid/ready  target handshake (ready only while idle)
//   tgt_pos          absolute target, two's complement
//   tgt_vel_div      requested velocity divider (clamped up to VEL_DIV_MIN)
//   abort            drop the unissued remainder of the current target
//   move_done        channel consumed one command (returns one credit)
//   newPosSignal     FIFO write strobe
//   deltaPos/moveDir/velocityMax_div  chunk payload, held after the strobe
//   cmd_pos          position after all issued chunks
//   credits          free FIFO slots
//   busy             target in flight or FIFO not yet drained
module motor_cmd_scheduler #(
  parameter int unsigned POS_W       = 32,
  parameter int unsigned MAX_CHUNK   = 65535,
  parameter int unsigned CREDITS     = 4,
  parameter logic [19:0] VEL_DIV_MIN = 20'h00115
) (
  input  logic             CLK_50MHZ,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [POS_W-1:0] tgt_pos,
  input  logic [19:0]      tgt_vel_div,
  input  logic             abort,
  input  logic             move_done,
  output logic             newPosSignal,
  output logic [15:0]      deltaPos,
  output logic             moveDir,
  output logic [19:0]      velocityMax_div,
  output logic [POS_W-1:0] cmd_pos,
  output logic [2:0]       credits,
  output logic             busy
);

  localparam logic [POS_W:0] MAX_CHUNK_W = (POS_W+1)'(MAX_CHUNK);
  localparam logic [2:0]     CRED_FULL   = 3'(CREDITS);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] tgt_pos_q, cmd_pos_q;
  logic [19:0]      vel_q, vel_clamped, vel_out_q;
  logic             dir_q, dir_out_q;
  logic [POS_W:0]   rem_q, diff, abs_diff, chunk;
  logic [15:0]      delta_q;
  logic [2:0]       credits_q, credits_d;
  logic             accept, issue, credit_ret;

  // Difference is taken one bit wider so any pair of POS_W positions fits.
  assign vel_clamped = (tgt_vel_div < VEL_DIV_MIN) ? VEL_DIV_MIN : tgt_vel_div;
  assign diff        = {tgt_pos_q[POS_W-1], tgt_pos_q} - {cmd_pos_q[POS_W-1], cmd_pos_q};
  assign abs_diff    = diff[POS_W] ? ('0 - diff) : diff;
  assign chunk       = (rem_q > MAX_CHUNK_W) ? MAX_CHUNK_W : rem_q;

  // State register
  always_ff @(posedge CLK_50MHZ) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = CALC;
      CALC:  if (abort || abs_diff == '0) state_d = IDLE;
             else                         state_d = ISSUE;
      // an abort in an issuing cycle still lets that strobe out
      ISSUE: if (abort || (issue && rem_q == chunk)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs of the FSM. The strobe is combinational so the first chunk is
  // written two cycles after accept and the scheduler is ready again in
  // the cycle right after the final strobe.
  always_comb begin
    tgt_ready  = (state_q == IDLE) && !rst;
    accept     = tgt_valid && tgt_ready;
    issue      = (state_q == ISSUE) && (credits_q != 3'd0) && !rst;
    credit_ret = move_done && (credits_q != CRED_FULL);
  end

  // A returned credit and an issued chunk in the same cycle cancel out.
  always_comb begin
    credits_d = credits_q;
    case ({issue, credit_ret})
      2'b10:   credits_d = credits_q - 3'd1;
      2'b01:   credits_d = credits_q + 3'd1;
      default: credits_d = credits_q;
    endcase
  end

  // Datapath
  always_ff @(posedge CLK_50MHZ) begin
    if (rst) begin
      tgt_pos_q <= '0;
      vel_q     <= '0;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      cmd_pos_q <= '0;
      credits_q <= CRED_FULL;
      delta_q   <= '0;
      dir_out_q <= 1'b0;
      vel_out_q <= '0;
    end else begin
      credits_q <= credits_d;
      if (accept) begin
        tgt_pos_q <= tgt_pos;
        vel_q     <= vel_clamped;
      end
      if (state_q == CALC) begin
        dir_q <= ~diff[POS_W];
        rem_q <= abs_diff;
      end
      if (issue) begin
        rem_q     <= rem_q - chunk;
        cmd_pos_q <= dir_q ? (cmd_pos_q + chunk[POS_W-1:0])
                           : (cmd_pos_q - chunk[POS_W-1:0]);
        delta_q   <= chunk[15:0];
        dir_out_q <= dir_q;
        vel_out_q <= vel_q;
      end
    end
  end

  // Payload shows the live chunk during the strobe, the last one otherwise.
  assign newPosSignal    = issue;
  assign deltaPos        = issue ? chunk[15:0] : delta_q;
  assign moveDir         = issue ? dir_q       : dir_out_q;
  assign velocityMax_div = issue ? vel_q       : vel_out_q;
  assign cmd_pos         = cmd_pos_q;
  assign credits         = credits_q;
  assign busy            = (state_q != IDLE) || (credits_q != CRED_FULL);

endmodule
